// File: rtl/aes_wb_regfile.sv
// rtl/aes_wb_regfile.sv - Wishbone register bank that loads, launches and collects results from the AES core
module aes_wb_regfile #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block,
    output logic         aes_decrypt,
    output logic         aes_start,
    input  logic         aes_valid,
    input  logic [127:0] aes_result,
    output logic         irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ack;
    logic [31:0] r_key    [4];
    logic [31:0] r_block  [4];
    logic [31:0] r_result [4];
    logic        r_irq_en;
    logic        r_ctrl_dec;
    logic        r_aes_dec;
    logic        r_done;
    logic        r_aes_start;

    logic        w_hit;
    logic        w_req;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic [7:0]  w_off;
    logic [1:0]  w_idx;
    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic        w_key_wr;
    logic        w_blk_wr;
    logic        w_launch;
    logic        w_capture;
    logic [31:0] w_mask;
    logic [31:0] w_rdata;
    logic        w_unused_adr;

    assign w_hit        = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign w_req        = wbs_stb_i & wbs_cyc_i & w_hit;
    // The ack cycle is the single cycle in which an access takes effect.
    assign w_acc        = r_ack & w_req;
    assign w_wr         = w_acc & wbs_we_i;
    assign w_rd         = w_acc & ~wbs_we_i;
    assign w_off        = wbs_adr_i[7:0];
    assign w_idx        = w_off[3:2];
    assign w_unused_adr = ^w_off[1:0];
    assign w_busy       = (r_state != S_IDLE);

    assign w_ctrl_wr = w_wr & (w_off[7:2] == 6'h00) & wbs_sel_i[0];
    assign w_stat_wr = w_wr & (w_off[7:2] == 6'h01) & wbs_sel_i[0];
    // Core inputs are frozen for the whole operation.
    assign w_key_wr  = w_wr & (w_off[7:4] == 4'h1) & ~w_busy;
    assign w_blk_wr  = w_wr & (w_off[7:4] == 4'h2) & ~w_busy;
    assign w_launch  = w_ctrl_wr & wbs_dat_i[0] & ~w_busy;
    assign w_capture = (r_state == S_WAIT) & aes_valid;

    assign w_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (aes_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_off[7:4])
            4'h0: begin
                if (w_idx == 2'd0)
                    w_rdata = {29'h0, r_ctrl_dec, r_irq_en, 1'b0};
                else if (w_idx == 2'd1)
                    w_rdata = {30'h0, r_done, w_busy};
            end
            4'h1:    w_rdata = r_key[w_idx];
            4'h2:    w_rdata = r_block[w_idx];
            4'h3:    w_rdata = r_result[w_idx];
            default: w_rdata = 32'h0;
        endcase
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = w_rd ? w_rdata : 32'h0;
    assign aes_key     = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign aes_block   = {r_block[0], r_block[1], r_block[2], r_block[3]};
    assign aes_decrypt = r_aes_dec;
    assign aes_start   = r_aes_start;
    assign irq         = r_done & r_irq_en;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_ack       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_ctrl_dec  <= 1'b0;
            r_aes_dec   <= 1'b0;
            r_done      <= 1'b0;
            r_aes_start <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_key[i]    <= 32'h0;
                r_block[i]  <= 32'h0;
                r_result[i] <= 32'h0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_req & ~r_ack;
            // Registered launch pulse: fires during the first WAIT cycle.
            r_aes_start <= (r_state == S_START);

            if (w_ctrl_wr) begin
                r_irq_en   <= wbs_dat_i[1];
                r_ctrl_dec <= wbs_dat_i[2];
            end
            if (w_launch)
                r_aes_dec <= wbs_dat_i[2];

            if (w_capture)
                r_done <= 1'b1;
            else if (w_launch || (w_stat_wr && wbs_dat_i[1]))
                r_done <= 1'b0;

            for (int i = 0; i < 4; i++) begin
                if (w_key_wr && (w_idx == i[1:0]))
                    r_key[i] <= (r_key[i] & ~w_mask) | (wbs_dat_i & w_mask);
                if (w_blk_wr && (w_idx == i[1:0]))
                    r_block[i] <= (r_block[i] & ~w_mask) | (wbs_dat_i & w_mask);
            end

            if (w_capture) begin
                r_result[0] <= aes_result[127:96];
                r_result[1] <= aes_result[95:64];
                r_result[2] <= aes_result[63:32];
                r_result[3] <= aes_result[31:0];
            end
        end
    end

endmodule

// File: tb/tb_aes_wb_regfile.sv
// tb/tb_aes_wb_regfile.sv - self-checking bench for aes_wb_regfile
module tb_aes_wb_regfile;

    localparam logic [31:0]  BASE = 32'h3000_0000;
    localparam logic [127:0] RES1 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    localparam logic [127:0] RES2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    logic         clk = 1'b0;
    logic         rst;
    logic         stb, cyc, we, valid;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_i, dat_o;
    logic         ack, dec, start, irq;
    logic [127:0] key, blk, result;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc_cnt   = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int ack_cyc   = 0;

    logic [31:0] m_key [4];
    logic [31:0] m_blk [4];
    logic [31:0] m_res [4];
    logic        m_done, m_busy, m_ien, m_cdec, m_dec;
    int          exp_start;

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[$];

    aes_wb_regfile #(.ADDR_BASE(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .aes_key(key), .aes_block(blk), .aes_decrypt(dec), .aes_start(start),
        .aes_valid(valid), .aes_result(result), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (start === 1'b1) begin start_cnt++; start_cyc = cyc_cnt; end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic valid_in_ack,
                        output logic [31:0] rd, output logic acked);
        acked = 1'b0;
        rd    = 32'h0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        for (int i = 0; i < 6 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin acked = 1'b1; rd = dat_o; ack_cyc = cyc_cnt; end
        end
        if (acked) begin
            if (valid_in_ack) valid = 1'b1;
            @(posedge clk); #1;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] rd;
        logic        a;
        xfer(1'b1, BASE | {24'h0, off}, 4'hF, d, 1'b0, rd, a);
        check($sformatf("wr%02h_ack", off), 128'(a), 128'd1);
        check($sformatf("wr%02h_dat_o", off), 128'(rd), 128'd0);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        a;
        xfer(1'b0, BASE | {24'h0, off}, 4'hF, 32'h0, 1'b0, rd, a);
        check({name, "_ack"}, 128'(a), 128'd1);
        check(name, 128'(rd), 128'(exp));
    endtask

    task automatic pulse_valid(input logic [127:0] r);
        repeat (2) @(negedge clk);
        result = r; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic add(input logic w, input logic [7:0] o, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.we = w; v.off = o; v.sel = s; v.dat = d; v.exp = e;
        vt.push_back(v);
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] off);
        int wi = int'(off[7:2]);
        if (wi == 0)      return {29'h0, m_cdec, m_ien, 1'b0};
        if (wi == 1)      return {30'h0, m_done, m_busy};
        if (wi >= 4 && wi < 8)   return m_key[wi - 4];
        if (wi >= 8 && wi < 12)  return m_blk[wi - 8];
        if (wi >= 12 && wi < 16) return m_res[wi - 12];
        return 32'h0;
    endfunction

    task automatic m_write(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
        int          wi = int'(off[7:2]);
        logic [31:0] w;
        if (wi == 0 && s[0]) begin
            m_ien = d[1]; m_cdec = d[2];
            if (d[0] && !m_busy) begin
                m_busy = 1'b1; m_done = 1'b0; m_dec = d[2]; exp_start++;
            end
        end else if (wi == 1 && s[0]) begin
            if (d[1]) m_done = 1'b0;
        end else if (wi >= 4 && wi < 12 && !m_busy) begin
            w = (wi < 8) ? m_key[wi - 4] : m_blk[wi - 8];
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            if (wi < 8) m_key[wi - 4] = w;
            else        m_blk[wi - 8] = w;
        end
    endtask

    initial begin
        logic [31:0]  rd, d;
        logic         a, w_we;
        logic [5:0]   pat;
        int           bad, la, start_base, kind;
        logic [7:0]   off;
        logic [3:0]   s;
        logic [127:0] r;

        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_i = 32'h0; valid = 1'b0; result = 128'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 128'(ack), 128'd0);
        check("rst_dat_o", 128'(dat_o), 128'd0);
        check("rst_key", key, 128'd0);
        check("rst_block", blk, 128'd0);
        check("rst_start", 128'(start), 128'd0);
        check("rst_decrypt", 128'(dec), 128'd0);
        check("rst_irq", 128'(irq), 128'd0);
        rst = 1'b0;

        add(1, 8'h10, 4'hF, 32'h00010203, 32'h0);
        add(1, 8'h14, 4'hF, 32'h04050607, 32'h0);
        add(1, 8'h18, 4'hF, 32'h08090A0B, 32'h0);
        add(1, 8'h1C, 4'hF, 32'h0C0D0E0F, 32'h0);
        add(1, 8'h20, 4'hF, 32'h00112233, 32'h0);
        add(1, 8'h24, 4'hF, 32'h44556677, 32'h0);
        add(1, 8'h28, 4'hF, 32'h8899AABB, 32'h0);
        add(1, 8'h2C, 4'hF, 32'hCCDDEEFF, 32'h0);
        add(0, 8'h10, 4'hF, 32'h0, 32'h00010203);
        add(0, 8'h2C, 4'hF, 32'h0, 32'hCCDDEEFF);
        add(0, 8'h04, 4'hF, 32'h0, 32'h0);
        add(0, 8'h80, 4'hF, 32'h0, 32'h0);
        add(1, 8'h30, 4'hF, 32'hFFFFFFFF, 32'h0);
        add(0, 8'h30, 4'hF, 32'h0, 32'h0);
        add(1, 8'h00, 4'hE, 32'h00000006, 32'h0);
        add(0, 8'h00, 4'hF, 32'h0, 32'h0);
        add(1, 8'h00, 4'h1, 32'h00000006, 32'h0);
        add(0, 8'h00, 4'hF, 32'h0, 32'h00000006);
        add(1, 8'h00, 4'hF, 32'h00000000, 32'h0);
        add(0, 8'h00, 4'hF, 32'h0, 32'h0);
        for (int i = 0; i < vt.size(); i++) begin
            xfer(vt[i].we, BASE | {24'h0, vt[i].off}, vt[i].sel, vt[i].dat, 1'b0, rd, a);
            check($sformatf("tbl%0d_ack", i), 128'(a), 128'd1);
            check($sformatf("tbl%0d_dat", i), 128'(rd), 128'(vt[i].exp));
        end
        check("key_out", key, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        check("block_out", blk, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Launch and start timing
        wr(8'h00, 32'h1);
        la = ack_cyc;
        rd_chk("launch_status", 8'h04, 32'h1);
        check("launch_start_cnt", 128'(start_cnt), 128'd1);
        check("launch_start_delay", 128'(start_cyc - la), 128'd2);
        check("launch_decrypt", 128'(dec), 128'd0);
        pulse_valid(RES1);
        rd_chk("res_w0", 8'h30, 32'h69C4E0D8);
        rd_chk("res_w3", 8'h3C, 32'h70B4C55A);
        rd_chk("done_status", 8'h04, 32'h2);
        check("done_irq_off", 128'(irq), 128'd0);

        // Interrupt and W1C
        wr(8'h00, 32'h3);
        pulse_valid(RES2);
        check("irq_on", 128'(irq), 128'd1);
        wr(8'h04, 32'h2);
        check("irq_w1c", 128'(irq), 128'd0);
        rd_chk("w1c_status", 8'h04, 32'h0);
        check("irq_start_cnt", 128'(start_cnt), 128'd2);

        // Capture and W1C in the same cycle: set wins
        wr(8'h00, 32'h3);
        result = RES1;
        xfer(1'b1, BASE | 32'h04, 4'hF, 32'h2, 1'b1, rd, a);
        check("setwins_ack", 128'(a), 128'd1);
        rd_chk("setwins_status", 8'h04, 32'h2);
        check("setwins_irq", 128'(irq), 128'd1);
        check("setwins_start_cnt", 128'(start_cnt), 128'd3);

        // Writes while busy
        wr(8'h00, 32'h5);
        rd_chk("busy_status", 8'h04, 32'h1);
        check("busy_decrypt", 128'(dec), 128'd1);
        wr(8'h10, 32'hFFFFFFFF);
        wr(8'h00, 32'h1);
        rd_chk("busy_key0", 8'h10, 32'h00010203);
        rd_chk("busy_ctrl", 8'h00, 32'h0);
        check("busy_decrypt_held", 128'(dec), 128'd1);
        check("busy_start_cnt", 128'(start_cnt), 128'd4);
        pulse_valid(RES1);
        rd_chk("busy_done", 8'h04, 32'h2);

        // Valid ignored in IDLE and START
        pulse_valid(RES2);
        rd_chk("idle_valid_res", 8'h30, 32'h69C4E0D8);
        rd_chk("idle_valid_status", 8'h04, 32'h2);
        wr(8'h00, 32'h1);
        @(negedge clk);
        result = RES2; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        rd_chk("start_valid_status", 8'h04, 32'h1);
        rd_chk("start_valid_res", 8'h30, 32'h69C4E0D8);
        check("start_valid_decrypt", 128'(dec), 128'd0);
        pulse_valid(RES2);
        rd_chk("wait_valid_res", 8'h30, 32'hDEADBEEF);
        check("fvalid_start_cnt", 128'(start_cnt), 128'd5);

        // Byte-lane write and unmapped read
        xfer(1'b1, BASE | 32'h10, 4'b0010, 32'h0000AB00, 1'b0, rd, a);
        check("byte_ack", 128'(a), 128'd1);
        check("byte_key", key, 128'h0001AB03_04050607_08090A0B_0C0D0E0F);
        rd_chk("unmapped_80", 8'h80, 32'h0);

        // Held strobe: one ack every other cycle, dat_o zero outside ack
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h10; sel = 4'hF;
        pat = 6'h0; bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = ack;
            if (!ack && dat_o != 32'h0) bad++;
        end
        stb = 1'b0; cyc = 1'b0;
        check("held_ack_pattern", 128'(pat), 128'(6'b010101));
        check("held_dat_o_idle", 128'(bad), 128'd0);

        // Outside the window
        xfer(1'b0, 32'h3000_0104, 4'hF, 32'h0, 1'b0, rd, a);
        check("oow_noack_0104", 128'(a), 128'd0);
        xfer(1'b1, 32'h3100_0010, 4'hF, 32'h12345678, 1'b0, rd, a);
        check("oow_noack_wr", 128'(a), 128'd0);
        rd_chk("oow_key_kept", 8'h10, 32'h0001AB03);

        // Reset during WAIT
        wr(8'h00, 32'h3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_valid(RES1);
        rd_chk("rstwait_status", 8'h04, 32'h0);
        rd_chk("rstwait_res", 8'h30, 32'h0);
        check("rstwait_irq", 128'(irq), 128'd0);
        check("rstwait_key", key, 128'd0);

        // Randomized traffic against the reference model
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin m_key[i] = 0; m_blk[i] = 0; m_res[i] = 0; end
        m_done = 0; m_busy = 0; m_ien = 0; m_cdec = 0; m_dec = 0; exp_start = 0;
        start_base = start_cnt;
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                pulse_valid(r);
                if (m_busy) begin
                    m_res[0] = r[127:96]; m_res[1] = r[95:64];
                    m_res[2] = r[63:32];  m_res[3] = r[31:0];
                    m_done = 1'b1; m_busy = 1'b0;
                end
            end else begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                w_we = 1'($urandom_range(0, 1));
                if (kind == 2) begin
                    off = 8'h00; w_we = 1'b1; s[0] = 1'b1;
                end else if (kind == 3) begin
                    off = 8'h04;
                end else if ($urandom_range(0, 4) == 0) begin
                    off = 8'($urandom_range(16, 63) * 4);
                end else begin
                    off = 8'($urandom_range(0, 15) * 4);
                end
                xfer(w_we, BASE | {24'h0, off} | 32'($urandom_range(0, 3)), s, d, 1'b0, rd, a);
                check("rnd_ack", 128'(a), 128'd1);
                if (w_we) begin
                    check("rnd_wr_dat", 128'(rd), 128'd0);
                    m_write(off, s, d);
                end else begin
                    check($sformatf("rnd_rd_%02h", off), 128'(rd), 128'(m_read(off)));
                end
            end
            check("rnd_key", key, {m_key[0], m_key[1], m_key[2], m_key[3]});
            check("rnd_block", blk, {m_blk[0], m_blk[1], m_blk[2], m_blk[3]});
            check("rnd_decrypt", 128'(dec), 128'(m_dec));
            check("rnd_irq", 128'(irq), 128'(m_done & m_ien));
        end
        repeat (4) @(negedge clk);
        check("rnd_start_cnt", 128'(start_cnt - start_base), 128'(exp_start));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
